// File: rtl/keypad_digit_ctrl.sv
// -----------------------------------------------------------------------------
// keypad_digit_ctrl
//
// Captures press events from a one-hot 10-key decimal pad, encodes each press
// to a BCD digit and writes it into a 4-entry x 4-bit digit store at an
// auto-incrementing address. On request the stored digits are scanned back
// out one at a time, each held for SCAN_HOLD cycles.
//
// Optional feature macro: KEYCTRL_OVERWRITE_EN
//   defined   : a press while the store is full overwrites the oldest entry
//               (wptr keeps wrapping), Cnt stays at 4, Ovf pulses.
//   undefined : a press while full is dropped, Ovf pulses.
//
// Parameters
//   SCAN_HOLD  cycles each digit is presented during a scan (1..15)
//
// Ports
//   CLK    in   1   rising-edge clock
//   RST    in   1   asynchronous active-low reset
//   Dec    in  10   keypad lines, bit i high = key i pressed
//   Clr    in   1   synchronous clear of stored count / write pointer
//   Rd     in   1   scan request
//   Dout   out  4   digit output (last written digit in IDLE, scanned in SCAN)
//   ADout  out  2   write pointer in IDLE, scan address in SCAN
//   Vld    out  1   Dout carries a scanned digit
//   Full   out  1   store holds 4 digits
//   Cnt    out  3   number of stored digits, 0..4
//   Ovf    out  1   one-cycle pulse after a press while full
// -----------------------------------------------------------------------------
module keypad_digit_ctrl #(
   parameter int unsigned SCAN_HOLD = 4
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [9:0] Dec,
   input  logic       Clr,
   input  logic       Rd,
   output logic [3:0] Dout,
   output logic [1:0] ADout,
   output logic       Vld,
   output logic       Full,
   output logic [2:0] Cnt,
   output logic       Ovf
);

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_e;

   localparam logic [3:0] HOLD_LAST = 4'(SCAN_HOLD - 1);

   state_e     state_q, state_d;
   logic [9:0] dec_q;
   logic [2:0] cnt_q, cnt_d;
   logic [1:0] wptr_q, wptr_d;
   logic [1:0] saddr_q, saddr_d;
   logic [3:0] hold_q, hold_d;
   logic       ovf_q, ovf_d;
   logic [3:0] mem_q [4];

   logic       press;
   logic       full;
   logic       mem_we;
   logic [3:0] code;

   // Highest set key wins; an all-zero pad encodes to 0 but never qualifies
   // as a press, so that value is never written.
   function automatic logic [3:0] enc_key(input logic [9:0] d);
      logic [3:0] k;
      k = 4'd0;
      for (int i = 0; i < 10; i++) begin
         if (d[i]) k = 4'(i);
      end
      return k;
   endfunction

   // A press is the first non-zero pad value after an all-zero cycle, so
   // held keys and roll-over between keys do not retrigger.
   assign press = (Dec != 10'd0) && (dec_q == 10'd0);
   assign full  = (cnt_q == 3'd4);
   assign code  = enc_key(Dec);

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= IDLE;
         dec_q   <= '0;
         cnt_q   <= '0;
         wptr_q  <= '0;
         saddr_q <= '0;
         hold_q  <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         dec_q   <= Dec;
         cnt_q   <= cnt_d;
         wptr_q  <= wptr_d;
         saddr_q <= saddr_d;
         hold_q  <= hold_d;
         ovf_q   <= ovf_d;
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         for (int i = 0; i < 4; i++) mem_q[i] <= '0;
      end else if (mem_we) begin
         mem_q[wptr_q] <= code;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wptr_d  = wptr_q;
      saddr_d = saddr_q;
      hold_d  = hold_q;
      ovf_d   = 1'b0;
      mem_we  = 1'b0;

      if (Clr) begin
         // Clear forgets the count but keeps the stored digits in mem.
         state_d = IDLE;
         cnt_d   = '0;
         wptr_d  = '0;
         saddr_d = '0;
         hold_d  = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (press) begin
                  if (!full) begin
                     mem_we = 1'b1;
                     wptr_d = wptr_q + 2'd1;
                     cnt_d  = cnt_q + 3'd1;
                  end else begin
                     ovf_d = 1'b1;
`ifdef KEYCTRL_OVERWRITE_EN
                     mem_we = 1'b1;
                     wptr_d = wptr_q + 2'd1;
`endif
                  end
               end
               // A same-cycle press guarantees at least one digit to show.
               if (Rd && ((cnt_q != 3'd0) || press)) begin
                  state_d = SCAN;
                  saddr_d = '0;
                  hold_d  = '0;
               end
            end
            SCAN: begin
               if (hold_q == HOLD_LAST) begin
                  hold_d = '0;
                  if ({1'b0, saddr_q} == (cnt_q - 3'd1)) begin
                     state_d = IDLE;
                  end else begin
                     saddr_d = saddr_q + 2'd1;
                  end
               end else begin
                  hold_d = hold_q + 4'd1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      Dout  = 4'd0;
      ADout = wptr_q;
      Vld   = 1'b0;
      if (state_q == SCAN) begin
         Dout  = mem_q[saddr_q];
         ADout = saddr_q;
         Vld   = 1'b1;
      end else if (cnt_q != 3'd0) begin
         Dout = mem_q[wptr_q - 2'd1];
      end
   end

   assign Full = full;
   assign Cnt  = cnt_q;
   assign Ovf  = ovf_q;

endmodule

// File: doc/keypad_digit_ctrl.md
# keypad_digit_ctrl

Sequencing controller for decimal keypad entry. It captures one-hot key presses from a 10-key pad and encodes each to a BCD digit. It writes the digits into an internal 4-entry x 4-bit digit store with an auto-incrementing address, and on request scans the stored digits back out one at a time for display. It sits between the keypad input and the display/memory datapath, replacing free-running shift capture with press-qualified, addressed writes.

## Interface

Parameters:

- SCAN_HOLD, 4: clock cycles each digit is presented during readback scan; legal range 1..15.

Ports:

- CLK  in  1  rising-edge clock.
- RST  in  1  asynchronous, active-low reset.
- Dec  in  10  keypad lines; bit i high = key i pressed.
- Clr  in  1  synchronous clear of the stored digit count.
- Rd  in  1  readback scan request, sampled each cycle.
- Dout  out  4  digit output.
- ADout  out  2  current store address.
- Vld  out  1  Dout is a scanned digit.
- Full  out  1  store holds 4 digits.
- Cnt  out  3  number of stored digits, 0..4.
- Ovf  out  1  one-cycle pulse on a press while Full.

## Operation

- Key encode: code = index of highest set bit of Dec (priority, bit 9 wins); Dec = 0 means no key.
- Press detect: Dec is registered each cycle into Dec_q. A press event is Dec != 0 and Dec_q == 0. Held keys and key changes without an all-zero release produce no further events.
- FSM states: IDLE, SCAN.
- IDLE:
  - On a press with Cnt < 4: mem[wptr] <= code, wptr <= wptr+1 (2-bit wrap), Cnt <= Cnt+1.
  - On a press with Cnt == 4, see Configuration.
  - Rd = 1 with Cnt > 0, or with a press in the same cycle: go to SCAN with saddr = 0 and hold = 0.
  - Rd = 1 with Cnt == 0 and no press: ignored.
- SCAN:
  - Presses are ignored and no Ovf is raised, but Dec_q still tracks Dec.
  - hold counts 0..SCAN_HOLD-1. At the end of each hold period saddr increments.
  - After the hold period of saddr == Cnt-1, go to IDLE.
  - Rd is ignored while in SCAN.
- Outputs:
  - IDLE: ADout = wptr. Dout = mem[wptr-1] when Cnt > 0, else 0. Vld = 0.
  - SCAN: ADout = saddr, Dout = mem[saddr], Vld = 1.
- Full = (Cnt == 4). Cnt saturates at 4.
- Clr (any state) sets Cnt = 0, wptr = 0 and state = IDLE. mem contents are retained. Clr has priority over a press and over Rd in the same cycle.

## Timing

- Reset (RST low, asynchronous): state IDLE, Cnt 0, wptr 0, saddr 0, hold 0, Dec_q 0, all mem entries 0. Outputs are Dout 0, ADout 0, Vld 0, Full 0, Cnt 0, Ovf 0.
- Reset mid-scan aborts the scan immediately. Vld drops asynchronously.
- Press to write takes 1 cycle. The edge that sees the event writes mem, and Cnt/ADout/Dout reflect the new digit in the following cycle.
- Rd to first scanned digit takes 1 cycle: Vld is high from the cycle after the Rd edge.
- The scan lasts exactly Cnt*SCAN_HOLD cycles. Vld is low the cycle after.
- A press and Rd in the same IDLE cycle: the digit is written on that edge and the scan includes it (Cnt already incremented).
- Ovf is high for exactly the one cycle after the rejected or overwriting press edge.

## Configuration

- KEYCTRL_OVERWRITE_EN defined: a press while Full writes mem[wptr] and increments wptr with 2-bit wrap, so the oldest digit is overwritten. Cnt stays 4 and Ovf pulses. The scan still reads physical addresses 0..3.
- KEYCTRL_OVERWRITE_EN undefined: a press while Full is dropped, mem and wptr are unchanged, and Ovf pulses.

## Test plan

- Reset, then press keys 3, 7, 1 (Dec = 0x008, 0x080, 0x002, each followed by Dec = 0) -> Cnt = 3, ADout = 3, Dout = 1, mem[0..2] = 3, 7, 1.
- Hold Dec = 0x200 for 10 cycles, then change to 0x201 without release -> exactly one write of 9.
- With 3, 7, 1 stored, SCAN_HOLD = 4, pulse Rd -> Vld high for 12 cycles. Dout/ADout are 3/0, 7/1, 1/2 for 4 cycles each, then Vld = 0 and ADout = 3.
- Fill with 1, 2, 3, 4, then press 5 -> Full = 1, Ovf pulses one cycle.
  - Macro undefined: mem = 1, 2, 3, 4.
  - Macro defined: mem[0] = 5 and ADout = 1.
- Press 6 and Rd in the same cycle with Cnt = 2 -> Cnt = 3 and the scan shows 3 digits, the last being 6.
- Assert RST low 5 cycles into a scan -> Vld = 0 and Cnt = 0 immediately; a subsequent Rd is ignored.
